// File: rtl/letc_core_amo_seq.sv
// Atomic memory operation sequencer. It runs one AMO, LR or SC at a time
// against the data memory subsystem as a load/modify/store pair, and keeps
// a single LR reservation that expires after RSV_TIMEOUT cycles.
//
// state   | meaning
// IDLE    | ready for a new request
// LD_REQ  | load presented, waiting for mem_req_ready (flush may still kill)
// LD_WAIT | load issued, waiting for its response (flush diverts to DRAIN)
// ST_REQ  | store presented; op is committed, flush ignored
// ST_WAIT | store issued, waiting for its response; result issued here
// DRAIN   | op was flushed during the load, swallowing the orphaned response
module letc_core_amo_seq #(
   parameter int unsigned RSV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_rs2,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        busy
);

   localparam logic [3:0] OP_SWAP = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MIN  = 4'd5;
   localparam logic [3:0] OP_MAX  = 4'd6;
   localparam logic [3:0] OP_MINU = 4'd7;
   localparam logic [3:0] OP_MAXU = 4'd8;
   localparam logic [3:0] OP_LR   = 4'd9;
   localparam logic [3:0] OP_SC   = 4'd10;

   localparam logic [7:0] RSV_LOAD = 8'(RSV_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      ST_REQ,
      ST_WAIT,
      DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rs2_q, rs2_d;
   logic [31:0] old_q, old_d;
   logic        sc_fail_q, sc_fail_d;

   logic        rsv_valid_q, rsv_valid_d;
   logic [31:0] rsv_addr_q, rsv_addr_d;
   logic [7:0]  rsv_cnt_q, rsv_cnt_d;

   logic        accept;
   logic        rsv_hit;
   logic        lr_done;
   logic        sc_done;
   logic        rmw_done;
   logic [31:0] store_data;

   assign accept  = req_valid && (state_q == IDLE) && !flush;
   assign rsv_hit = rsv_valid_q && (rsv_addr_q == req_addr);

   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign mem_req_we    = (state_q == ST_REQ);
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = (state_q == ST_REQ) ? store_data : 32'd0;

   // Store value from the loaded word and the operand; unknown ops behave as SWAP.
   always_comb begin
      store_data = rs2_q;
      unique case (op_q)
         OP_ADD:  store_data = old_q + rs2_q;
         OP_AND:  store_data = old_q & rs2_q;
         OP_OR:   store_data = old_q | rs2_q;
         OP_XOR:  store_data = old_q ^ rs2_q;
         OP_MIN:  store_data = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
         OP_MAX:  store_data = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
         OP_MINU: store_data = (old_q < rs2_q) ? old_q : rs2_q;
         OP_MAXU: store_data = (old_q > rs2_q) ? old_q : rs2_q;
         default: store_data = rs2_q;
      endcase
   end

   // Sequencer next state, memory handshake and result pulse.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      rs2_d         = rs2_q;
      old_d         = old_q;
      sc_fail_d     = 1'b0;
      mem_req_valid = 1'b0;
      res_valid     = 1'b0;
      res_data      = 32'd0;
      lr_done       = 1'b0;
      sc_done       = 1'b0;
      rmw_done      = 1'b0;

      // A failed SC reports one cycle after acceptance while already back in IDLE.
      if (sc_fail_q) begin
         res_valid = 1'b1;
         res_data  = 32'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d   = (req_op > OP_SC) ? OP_SWAP : req_op;
               addr_d = req_addr;
               rs2_d  = req_rs2;
               if (req_op == OP_SC) begin
                  if (rsv_hit) state_d = ST_REQ;
                  else         sc_fail_d = 1'b1;
               end else begin
                  state_d = LD_REQ;
               end
            end
         end
         LD_REQ: begin
            // Valid is withdrawn under flush so the killed load never reaches memory.
            if (flush) begin
               state_d = IDLE;
            end else begin
               mem_req_valid = 1'b1;
               if (mem_req_ready) state_d = LD_WAIT;
            end
         end
         LD_WAIT: begin
            if (mem_rsp_valid) begin
               old_d = mem_rsp_rdata;
               // Flush coinciding with the response needs no drain: nothing is left pending.
               if (flush) begin
                  state_d = IDLE;
               end else if (op_q == OP_LR) begin
                  res_valid = 1'b1;
                  res_data  = mem_rsp_rdata;
                  lr_done   = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = ST_REQ;
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               res_valid = 1'b1;
               if (op_q == OP_SC) begin
                  res_data = 32'd0;
                  sc_done  = 1'b1;
               end else begin
                  res_data = old_q;
                  rmw_done = 1'b1;
               end
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (mem_rsp_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reservation: timed expiry, cleared by SC completion or an RMW to the same word.
   always_comb begin
      rsv_valid_d = rsv_valid_q;
      rsv_addr_d  = rsv_addr_q;
      rsv_cnt_d   = rsv_cnt_q;

      if (rsv_valid_q) begin
         if (rsv_cnt_q <= 8'd1) begin
            rsv_valid_d = 1'b0;
            rsv_cnt_d   = 8'd0;
         end else begin
            rsv_cnt_d = rsv_cnt_q - 8'd1;
         end
      end

      if (sc_done || (rmw_done && (addr_q == rsv_addr_q))) begin
         rsv_valid_d = 1'b0;
         rsv_cnt_d   = 8'd0;
      end

      if (lr_done) begin
         rsv_valid_d = 1'b1;
         rsv_addr_d  = addr_q;
         rsv_cnt_d   = RSV_LOAD;
      end
   end

   // State and datapath registers; reset abandons any outstanding access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_SWAP;
         addr_q      <= 32'd0;
         rs2_q       <= 32'd0;
         old_q       <= 32'd0;
         sc_fail_q   <= 1'b0;
         rsv_valid_q <= 1'b0;
         rsv_addr_q  <= 32'd0;
         rsv_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         rs2_q       <= rs2_d;
         old_q       <= old_d;
         sc_fail_q   <= sc_fail_d;
         rsv_valid_q <= rsv_valid_d;
         rsv_addr_q  <= rsv_addr_d;
         rsv_cnt_q   <= rsv_cnt_d;
      end
   end

`ifndef SYNTHESIS
   // Responses are only meaningful while a memory access is outstanding.
   a_rsp_in_wait: assert property (@(posedge clk) disable iff (rst)
      mem_rsp_valid |-> (state_q inside {LD_WAIT, ST_WAIT, DRAIN}));
`endif

endmodule

// File: tb/tb_letc_core_amo_seq.sv
// Bench for the AMO sequencer: directed scenarios plus randomized ops,
// all checked against a transaction-level memory/reservation model.
module tb_letc_core_amo_seq;

   localparam int RSV = 8;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_MIN  = 4'd5;
   localparam logic [3:0] OP_MINU = 4'd7;
   localparam logic [3:0] OP_LR   = 4'd9;
   localparam logic [3:0] OP_SC   = 4'd10;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_rs2;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        res_valid;
   logic [31:0] res_data;
   logic        busy;

   letc_core_amo_seq #(.RSV_TIMEOUT(RSV)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_addr      (req_addr),
      .req_rs2       (req_rs2),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- memory subsystem model ----------------
   logic [31:0] dmss_mem [logic [31:0]];
   int          ready_mode = 0;   // 0 always, 1 random, 2 never, 3 loads only
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          mem_acc = 0;
   logic [31:0] last_addr;
   logic [31:0] last_wdata;
   logic        last_we;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_data;
   bit          stall_prev;
   logic [31:0] sp_addr;
   logic [31:0] sp_wdata;
   logic        sp_we;

   initial begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'd0;
      pend          = 1'b0;
      stall_prev    = 1'b0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (rst) begin
            pend          = 1'b0;
            stall_prev    = 1'b0;
            mem_req_ready = 1'b0;
         end else begin
            if (pend) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_rdata = pend_data;
                  pend          = 1'b0;
               end
            end
            case (ready_mode)
               0:       mem_req_ready = 1'b1;
               1:       mem_req_ready = ($urandom_range(0, 9) < 7);
               2:       mem_req_ready = 1'b0;
               default: mem_req_ready = !mem_req_we;
            endcase
            #1;
            if (mem_req_valid && stall_prev) begin
               chk("hold_addr", mem_req_addr, sp_addr);
               chk("hold_we", mem_req_we, sp_we);
               chk("hold_wdata", mem_req_wdata, sp_wdata);
            end
            stall_prev = mem_req_valid && !mem_req_ready;
            sp_addr    = mem_req_addr;
            sp_we      = mem_req_we;
            sp_wdata   = mem_req_wdata;
            if (mem_req_valid && mem_req_ready) begin
               mem_acc++;
               last_addr  = mem_req_addr;
               last_we    = mem_req_we;
               last_wdata = mem_req_wdata;
               pend_data  = dmss_mem[mem_req_addr];
               if (mem_req_we) dmss_mem[mem_req_addr] = mem_req_wdata;
               pend     = 1'b1;
               pend_cnt = $urandom_range(lat_lo, lat_hi);
            end
         end
      end
   end

   int res_cnt = 0;
   initial forever begin
      @(negedge clk);
      #1;
      if (res_valid) res_cnt++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [logic [31:0]];
   bit          rsv_live = 1'b0;
   logic [31:0] rsv_addr_m;
   int          rsv_until;
   int          exp_pulses = 0;
   bit          busy_hist [0:63];

   function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] old,
                                           input logic [31:0] src);
      int so;
      int ss;
      so = old;
      ss = src;
      case (op)
         4'd1:    return old + src;
         4'd2:    return old & src;
         4'd3:    return old | src;
         4'd4:    return old ^ src;
         4'd5:    return (so < ss) ? old : src;
         4'd6:    return (so > ss) ? old : src;
         4'd7:    return (old < src) ? old : src;
         4'd8:    return (old > src) ? old : src;
         default: return src;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input int gap, input int flush_at, input int budget,
                         output int acc_cyc, output int lat, output bit got,
                         output logic [31:0] data);
      int k;
      repeat (gap) @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_rs2   = rs2;
      #2;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         #2;
         k++;
      end
      chk("accept", req_ready, 1'b1);
      acc_cyc = cyc;
      got     = 1'b0;
      lat     = 0;
      data    = 32'd0;
      for (int i = 1; i <= budget && !got; i++) begin
         @(negedge clk);
         if (i == 1) req_valid = 1'b0;
         flush = (i == flush_at);
         #2;
         if (i < 64) busy_hist[i] = busy;
         if (res_valid) begin
            got  = 1'b1;
            lat  = cyc - acc_cyc;
            data = res_data;
         end
      end
      req_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                        input int gap, input int flush_at,
                        output int lat, output logic [31:0] data);
      int          acc;
      int          acc0;
      bit          got;
      logic [3:0]  eop;
      logic [31:0] exp;
      int          exp_acc;
      acc0 = mem_acc;
      run_op(op, addr, rs2, gap, flush_at, 300, acc, lat, got, data);
      chk("res_seen", got, 1'b1);
      eop = (op > OP_SC) ? 4'd0 : op;
      if (eop == OP_LR) begin
         exp        = ref_mem[addr];
         rsv_live   = 1'b1;
         rsv_addr_m = addr;
         rsv_until  = acc + lat + RSV;
         exp_acc    = 1;
      end else if (eop == OP_SC) begin
         if (rsv_live && rsv_addr_m == addr && acc <= rsv_until) begin
            exp           = 32'd0;
            ref_mem[addr] = rs2;
            rsv_live      = 1'b0;
            exp_acc       = 1;
         end else begin
            exp     = 32'd1;
            exp_acc = 0;
            chk("sc_fail_lat", lat, 1);
         end
      end else begin
         exp           = ref_mem[addr];
         ref_mem[addr] = amo_ref(eop, exp, rs2);
         if (rsv_live && rsv_addr_m == addr) rsv_live = 1'b0;
         exp_acc = 2;
      end
      chk("res_data", data, exp);
      chk("mem_word", dmss_mem[addr], ref_mem[addr]);
      chk("mem_accesses", mem_acc - acc0, exp_acc);
      exp_pulses++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          lat;
      int          acc;
      int          acc0;
      int          rc0;
      bit          got;
      logic [31:0] data;
      logic [31:0] addrs [5];
      logic [3:0]  op;
      int          r;

      addrs = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h300};
      foreach (addrs[i]) begin
         r = $urandom;
         dmss_mem[addrs[i]] = r;
         ref_mem[addrs[i]]  = r;
      end
      dmss_mem[32'h100] = 32'd7;  ref_mem[32'h100] = 32'd7;
      dmss_mem[32'h104] = 32'd3;  ref_mem[32'h104] = 32'd3;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_addr  = 32'd0;
      req_rs2   = 32'd0;
      flush     = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_mem_valid", mem_req_valid, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_res_data", res_data, 32'd0);
      rst = 1'b0;

      // ADD with fastest memory: load 7, store 12, result 7 four cycles after acceptance
      do_op(OP_ADD, 32'h100, 32'd5, 1, 0, lat, data);
      chk("add_res", data, 32'd7);
      chk("add_lat", lat, 4);
      chk("add_wdata", last_wdata, 32'd12);
      chk("add_we", last_we, 1'b1);

      do_op(OP_MIN, 32'h104, 32'hFFFF_FFFF, 1, 0, lat, data);
      chk("min_wdata", last_wdata, 32'hFFFF_FFFF);
      dmss_mem[32'h104] = 32'd3;
      ref_mem[32'h104]  = 32'd3;
      do_op(OP_MINU, 32'h104, 32'hFFFF_FFFF, 1, 0, lat, data);
      chk("minu_wdata", last_wdata, 32'd3);

      // LR/SC pairing, then a second SC after the reservation is consumed
      do_op(OP_LR, 32'h200, 32'd0, 1, 0, lat, data);
      chk("lr_lat", lat, 2);
      do_op(OP_SC, 32'h200, 32'd9, 3, 0, lat, data);
      chk("sc_ok_res", data, 32'd0);
      chk("sc_ok_wdata", last_wdata, 32'd9);
      do_op(OP_SC, 32'h200, 32'd4, 1, 0, lat, data);
      chk("sc_again_res", data, 32'd1);

      // Reservation lifetime boundary: last live cycle, then one past it
      do_op(OP_LR, 32'h200, 32'd0, 1, 0, lat, data);
      do_op(OP_SC, 32'h200, 32'd21, RSV, 0, lat, data);
      chk("sc_edge_res", data, 32'd0);
      do_op(OP_LR, 32'h200, 32'd0, 1, 0, lat, data);
      do_op(OP_SC, 32'h200, 32'd22, RSV + 1, 0, lat, data);
      chk("sc_expired_res", data, 32'd1);
      do_op(OP_LR, 32'h200, 32'd0, 1, 0, lat, data);
      do_op(OP_SC, 32'h204, 32'd23, 1, 0, lat, data);
      chk("sc_other_addr", data, 32'd1);

      do_op(4'd13, 32'h300, 32'h0000_ABCD, 1, 0, lat, data);
      chk("unknown_swap", last_wdata, 32'h0000_ABCD);

      // Flush while the load is still being presented
      ready_mode = 2;
      acc0 = mem_acc;
      rc0  = res_cnt;
      run_op(OP_ADD, 32'h104, 32'd1, 1, 1, 6, acc, lat, got, data);
      chk("flush_ldreq_nores", got, 1'b0);
      chk("flush_ldreq_noacc", mem_acc - acc0, 0);
      chk("flush_ldreq_idle", busy_hist[2], 1'b0);
      chk("flush_ldreq_pulses", res_cnt - rc0, 0);
      ready_mode = 0;

      // Flush while waiting for the load response: drain it, no result
      lat_lo = 3;
      lat_hi = 3;
      acc0 = mem_acc;
      rc0  = res_cnt;
      run_op(OP_ADD, 32'h104, 32'd1, 1, 2, 8, acc, lat, got, data);
      chk("drain_nores", got, 1'b0);
      chk("drain_busy", busy_hist[3], 1'b1);
      chk("drain_idle", busy_hist[5], 1'b0);
      chk("drain_loads", mem_acc - acc0, 1);
      chk("drain_mem", dmss_mem[32'h104], ref_mem[32'h104]);
      chk("drain_pulses", res_cnt - rc0, 0);

      // Flush during the committed store is ignored
      do_op(OP_ADD, 32'h104, 32'd10, 1, 6, lat, data);
      chk("flush_st_lat", lat, 8);

      // Reset in the middle of a stalled store
      lat_lo = 1;
      lat_hi = 1;
      ready_mode = 3;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_ADD;
      req_addr  = 32'h204;
      req_rs2   = 32'd77;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk("stalled_store", {mem_req_valid, mem_req_we}, 2'b11);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #2;
      chk("rst_mid_mem_valid", mem_req_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_ready", req_ready, 1'b1);
      rst = 1'b0;
      rsv_live = 1'b0;
      chk("rst_mid_mem", dmss_mem[32'h204], ref_mem[32'h204]);
      ready_mode = 0;

      // Randomized ops with stalls and variable response latency
      lat_hi = 3;
      for (int n = 0; n < 150; n++) begin
         ready_mode = $urandom_range(0, 1);
         r = $urandom_range(0, 21);
         if (r >= 16) op = (r < 19) ? OP_LR : OP_SC;
         else         op = 4'(r);
         case ($urandom_range(0, 3))
            0:       data = $urandom;
            1:       data = $urandom_range(0, 15);
            2:       data = 32'h8000_0000 | $urandom_range(0, 3);
            default: data = 32'hFFFF_FFF0 | $urandom_range(0, 15);
         endcase
         do_op(op, addrs[$urandom_range(0, 4)], data, $urandom_range(1, RSV + 3), 0, lat, data);
      end
      ready_mode = 0;

      repeat (3) @(negedge clk);
      #2;
      chk("res_pulses", res_cnt, exp_pulses);
      foreach (addrs[i]) chk("final_mem", dmss_mem[addrs[i]], ref_mem[addrs[i]]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/letc_core_amo_seq.md
LETC_CORE_AMO_SEQ -- requirements
Module: letc_core_amo_seq

Interface
REQ-001 The block SHALL have one parameter: RSV_TIMEOUT, default 64, the number of cycles after which an LR reservation expires (legal range 1..255).
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  AMO/LR/SC request present
- req_ready  out  1  sequencer accepts request
- req_op  in  4  0 SWAP, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU, 9 LR, 10 SC
- req_addr  in  32  word address
- req_rs2  in  32  source operand
- flush  in  1  kill request not yet committed
- mem_req_valid  out  1  DMSS request
- mem_req_ready  in  1  DMSS accepts
- mem_req_we  out  1  1 store, 0 load
- mem_req_addr  out  32  DMSS address
- mem_req_wdata  out  32  store data
- mem_rsp_valid  in  1  DMSS response, one per accepted request, in order
- mem_rsp_rdata  in  32  load data
- res_valid  out  1  one-cycle result pulse
- res_data  out  32  rd value
- busy  out  1  state != IDLE

Function
REQ-003 The block SHALL use states IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT, DRAIN.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready && !flush, latching op, addr and rs2.
REQ-005 On acceptance: LR and all RMW ops SHALL go to LD_REQ; SC with a valid reservation at the same addr SHALL go to ST_REQ; SC otherwise SHALL pulse res_valid with res_data=1 on the next cycle and return to IDLE without any memory access.
REQ-006 In LD_REQ and ST_REQ, mem_req_valid SHALL be 1 and SHALL hold with stable addr, we and wdata until mem_req_ready; on handshake the block SHALL move to LD_WAIT or ST_WAIT respectively.
REQ-007 In LD_WAIT, on mem_rsp_valid the block SHALL capture rdata into old_val; LR SHALL then pulse res_valid with res_data=old_val, set the reservation (addr, valid=1, counter=RSV_TIMEOUT) and return to IDLE; RMW ops SHALL go to ST_REQ.
REQ-008 The store data SHALL be: SWAP rs2; ADD old+rs2 mod 2^32; AND, OR, XOR bitwise; MIN/MAX signed compare; MINU/MAXU unsigned compare; SC rs2.
REQ-009 In ST_WAIT, on mem_rsp_valid the block SHALL pulse res_valid with res_data = old_val (RMW) or 0 (SC) and return to IDLE; SC SHALL clear the reservation in the same cycle.
REQ-010 Minimum latency SHALL be: RMW 4 cycles from acceptance to res_valid, with mem_req_ready=1 and responses the cycle after each handshake; LR 2 cycles; failing SC 1 cycle.
REQ-011 flush in LD_REQ SHALL return the block to IDLE with no access issued; flush in LD_WAIT SHALL go to DRAIN, which discards the pending response and then goes to IDLE; no res_valid SHALL be produced for a flushed op.
REQ-012 flush in ST_REQ or ST_WAIT SHALL be ignored, because the op is committed.
REQ-013 The reservation counter SHALL decrement each cycle while valid and SHALL clear valid on reaching 0; any RMW store to the reserved addr SHALL clear the reservation; a new LR SHALL overwrite it.
REQ-014 An unknown op (11..15) SHALL be treated as SWAP.
REQ-015 A response arriving in any state other than LD_WAIT, ST_WAIT or DRAIN SHALL be ignored (flagged by an assertion in simulation).

Reset
REQ-016 On rst the block SHALL go to IDLE immediately, including mid-operation, and SHALL drive req_ready=1 and mem_req_valid=0, res_valid=0, busy=0, res_data=0; the reservation SHALL be invalid with counter 0.
REQ-017 An outstanding DMSS transaction SHALL be abandoned at reset; resetting the DMSS alongside is the system's responsibility.

Verification
REQ-018 ADD, addr 0x100, rs2 5, memory holds 7 -> load, then store wdata 12; res_data=7 at cycle 4.
REQ-019 MIN, rs2 0xFFFFFFFF, memory holds 3 -> store 0xFFFFFFFF; MINU with the same values -> store 3.
REQ-020 LR 0x200 then SC 0x200 with rs2 9 within 10 cycles -> store 9, res_data=0; a second SC -> res_data=1 with no memory access.
REQ-021 LR 0x200, wait RSV_TIMEOUT+1 cycles, SC 0x200 -> res_data=1; SC to 0x204 after LR 0x200 -> res_data=1.
REQ-022 flush in LD_WAIT -> DRAIN, response discarded, no res_valid; flush in ST_WAIT -> store completes and res_valid fires.
REQ-023 Assert rst during ST_REQ with mem_req_ready=0 -> the next cycle shows mem_req_valid=0, busy=0, req_ready=1.
